clken_sched: RTL



---
 rtl/clken_sched_pkg.sv | 13 +
 rtl/clken_sched_if.sv | 27 ++
 rtl/clken_counter.sv | 42 ++++
 rtl/clken_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/clken_sched_pkg.sv
// Shared constants and state encoding for the clock-enable scheduler.
package clken_sched_pkg;

    localparam int CLK_CNT_W       = 17;  // divide counter / ratio width
    localparam int CLK_DEFAULT_DIV = 2;   // ratio loaded at reset
    localparam int CLK_TCNT_W      = 8;   // tick counter width

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/clken_sched_if.sv
// Control/status bundle between the top-level controller and clken_sched.
interface clken_sched_if #(
    parameter int CNT_W  = clken_sched_pkg::CLK_CNT_W,
    parameter int TCNT_W = clken_sched_pkg::CLK_TCNT_W
);
    logic              start;
    logic              stop;
    logic              cfg_valid;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic              running;
    logic              tick;
    logic              dclk;
    logic [TCNT_W-1:0] tick_cnt;

    // Controller side: issues commands and ratios, observes status.
    modport master (
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, running, tick, dclk, tick_cnt
    );

    // Scheduler side.
    modport slave (
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, running, tick, dclk, tick_cnt
    );
endinterface

// File: rtl/clken_counter.sv
// Divide counter: counts 0..div-1 while enabled, reloads div on a load strobe.
module clken_counter
    import clken_sched_pkg::*;
#(
    parameter int CNT_W       = CLK_CNT_W,
    parameter int DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,        // counting; low holds cnt at 0
    input  logic             load,      // take load_div as the new ratio
    input  logic [CNT_W-1:0] load_div,
    output logic             wrap       // cnt is at the last count of the period
);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;

    assign wrap = (cnt == div - ONE);

    // Period counter; cleared whenever counting is disabled and on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // Active ratio; the caller only strobes load at a period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= DIV_RST;
        end else if (load) begin
            div <= load_div;
        end
    end
endmodule

// File: rtl/clken_sched.sv
// Clock-enable scheduler: tick every N cycles, divided level dclk, and a
// ratio handshake whose new values land only on period boundaries.
module clken_sched
    import clken_sched_pkg::*;
#(
    parameter int CNT_W       = CLK_CNT_W,
    parameter int DEFAULT_DIV = CLK_DEFAULT_DIV,
    parameter int TCNT_W      = CLK_TCNT_W
) (
    input  logic          clk,
    input  logic          rst,
    clken_sched_if.slave  bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t            state, state_next;
    logic              wrap;
    logic              count_en, stop_edge, wrap_edge, accept, apply;
    logic              pending, pending_next;
    logic [CNT_W-1:0]  pend_div, pend_div_next;
    logic              rdy, rdy_next;
    logic              run_lvl, run_lvl_next;
    logic              tick_pulse, tick_next;
    logic              dclk_lvl, dclk_next;
    logic [TCNT_W-1:0] ticks, ticks_next;

    // stop has priority over everything else in RUN, including a wrap.
    assign stop_edge = (state == RUN) && bus.stop;
    assign count_en  = (state == RUN) && !bus.stop;
    assign wrap_edge = count_en && wrap;
    assign accept    = bus.cfg_valid && rdy;
    // A pending ratio may only land where the counter is (or becomes) zero.
    assign apply     = pending && ((state == IDLE) || wrap_edge || stop_edge);

    clken_counter #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (count_en),
        .load     (apply),
        .load_div (pend_div),
        .wrap     (wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start enters RUN unless stop is also present; stop leaves RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && !bus.stop) state_next = RUN;
            RUN:     if (bus.stop)               state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and the pending ratio.
    always_comb begin
        run_lvl_next  = (state_next == RUN);
        tick_next     = wrap_edge;
        dclk_next     = count_en ? (dclk_lvl ^ wrap) : 1'b0;
        ticks_next    = ticks + {{(TCNT_W-1){1'b0}}, wrap_edge};
        pending_next  = pending;
        pend_div_next = pend_div;
        rdy_next      = rdy;
        if (accept) begin
            pending_next  = 1'b1;
            pend_div_next = (bus.cfg_div == '0) ? ONE : bus.cfg_div;
            rdy_next      = 1'b0;
        end else if (apply) begin
            pending_next  = 1'b0;
            rdy_next      = 1'b1;
        end
    end

    // Output and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_lvl    <= 1'b0;
            tick_pulse <= 1'b0;
            dclk_lvl   <= 1'b0;
            ticks      <= '0;
            pending    <= 1'b0;
            pend_div   <= '0;
            rdy        <= 1'b1;
        end else begin
            run_lvl    <= run_lvl_next;
            tick_pulse <= tick_next;
            dclk_lvl   <= dclk_next;
            ticks      <= ticks_next;
            pending    <= pending_next;
            pend_div   <= pend_div_next;
            rdy        <= rdy_next;
        end
    end

    assign bus.cfg_ready = rdy;
    assign bus.running   = run_lvl;
    assign bus.tick      = tick_pulse;
    assign bus.dclk      = dclk_lvl;
    assign bus.tick_cnt  = ticks;
endmodule
